// File: rtl/apple_pkg.sv
// Shared definitions for the apple field controller: geometry widths,
// default placement table, LFSR seed/taps and scheduler states.
package apple_pkg;

  localparam int unsigned APPLE_W    = 10;
  localparam int unsigned APPLE_YW   = 9;
  localparam int unsigned APPLE_SIZE = 14;
  localparam int unsigned MAX_APPLES = 8;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {IDLE, SCAN} state_t;

  // Default X position of slot i
  function automatic logic [APPLE_W-1:0] def_x(input int i);
    case (i)
      0:       return 10'd35;
      1:       return 10'd135;
      2:       return 10'd205;
      3:       return 10'd440;
      4:       return 10'd600;
      5:       return 10'd320;
      6:       return 10'd60;
      7:       return 10'd560;
      default: return 10'd0;
    endcase
  endfunction

  // Default Y position of slot i
  function automatic logic [APPLE_YW-1:0] def_y(input int i);
    case (i)
      0:       return 9'd80;
      1:       return 9'd300;
      2:       return 9'd400;
      3:       return 9'd290;
      4:       return 9'd50;
      5:       return 9'd240;
      6:       return 9'd420;
      7:       return 9'd200;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/apple_lfsr.sv
// Free-running 16-bit Galois LFSR plus range fold producing a legal
// on-screen (x, y) every cycle.
// Ports: clk, rst (sync, active-high), x [APPLE_W], y [APPLE_YW] (registered).
module apple_lfsr
  import apple_pkg::*;
#(
  parameter int unsigned X_MAX = 626,
  parameter int unsigned Y_MAX = 466
) (
  input  logic                clk,
  input  logic                rst,
  output logic [APPLE_W-1:0]  x,
  output logic [APPLE_YW-1:0] y
);

  logic [15:0]         lfsr;
  logic [15:0]         lfsr_d;
  logic [APPLE_W-1:0]  x_raw;
  logic [APPLE_YW-1:0] y_raw;
  logic [APPLE_W-1:0]  x_d;
  logic [APPLE_YW-1:0] y_d;

  // Next LFSR state and folded coordinates; folding keeps values in range
  always_comb begin
    lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    x_raw  = lfsr[9:0];
    y_raw  = {lfsr[15:10], lfsr[2:0]};
    x_d    = (x_raw > APPLE_W'(X_MAX))  ? x_raw - 10'd512 : x_raw;
    y_d    = (y_raw > APPLE_YW'(Y_MAX)) ? y_raw - 9'd256  : y_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
      x    <= '0;
      y    <= '0;
    end else begin
      lfsr <= lfsr_d;
      x    <= x_d;
      y    <= y_d;
    end
  end

endmodule

// File: rtl/apple_scheduler.sv
// Apple field controller: once per frame tick, scans every apple slot,
// consuming latched collisions, scoring, and timing respawns.
// Optional macro APPLE_LFSR_RESPAWN_EN: respawn at a pseudo-random position
// instead of the slot's default position.
// Ports: clk, rst (sync, active-high), update (frame tick), hit[N] (collisions);
//        apple_x[N*10], apple_y[N*9], active[N], score[8], eat_pulse, busy.
module apple_scheduler
  import apple_pkg::*;
#(
  parameter int unsigned NUM_APPLES     = 5,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned X_MAX          = 626,
  parameter int unsigned Y_MAX          = 466
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           update,
  input  logic [NUM_APPLES-1:0]          hit,
  output logic [NUM_APPLES*APPLE_W-1:0]  apple_x,
  output logic [NUM_APPLES*APPLE_YW-1:0] apple_y,
  output logic [NUM_APPLES-1:0]          active,
  output logic [7:0]                     score,
  output logic                           eat_pulse,
  output logic                           busy
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TW    = 8;

  state_t                         state, state_d;
  logic [IDX_W-1:0]               idx, idx_d;
  logic                           busy_d;
  logic [NUM_APPLES-1:0]          active_d;
  logic [NUM_APPLES-1:0]          hit_latch, hit_latch_d;
  logic [NUM_APPLES-1:0]          clr;
  logic [TW-1:0]                  timer   [NUM_APPLES];
  logic [TW-1:0]                  timer_d [NUM_APPLES];
  logic [7:0]                     score_d;
  logic                           eat_d;
  logic [NUM_APPLES*APPLE_W-1:0]  x_d;
  logic [NUM_APPLES*APPLE_YW-1:0] y_d;

  // Home position of a slot, clamped into the configured field
  function automatic logic [APPLE_W-1:0] home_x(input int i);
    logic [APPLE_W-1:0] d;
    d = def_x(i);
    return (d > APPLE_W'(X_MAX)) ? APPLE_W'(X_MAX) : d;
  endfunction

  function automatic logic [APPLE_YW-1:0] home_y(input int i);
    logic [APPLE_YW-1:0] d;
    d = def_y(i);
    return (d > APPLE_YW'(Y_MAX)) ? APPLE_YW'(Y_MAX) : d;
  endfunction

`ifdef APPLE_LFSR_RESPAWN_EN
  logic [APPLE_W-1:0]  rnd_x;
  logic [APPLE_YW-1:0] rnd_y;

  apple_lfsr #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .x   (rnd_x),
    .y   (rnd_y)
  );
`endif

  // Next-state and slot servicing
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    busy_d   = busy;
    active_d = active;
    timer_d  = timer;
    score_d  = score;
    eat_d    = 1'b0;
    x_d      = apple_x;
    y_d      = apple_y;
    clr      = '0;

    case (state)
      IDLE: begin
        if (update) begin
          state_d = SCAN;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        for (int i = 0; i < int'(NUM_APPLES); i++) begin
          if (idx == IDX_W'(i)) begin
            clr[i] = 1'b1;
            if (active[i]) begin
              if (hit_latch[i]) begin
                active_d[i] = 1'b0;
                timer_d[i]  = TW'(RESPAWN_FRAMES);
                if (score != 8'hFF) score_d = score + 8'd1;
                eat_d = 1'b1;
              end
            end else if (timer[i] > 8'd1) begin
              timer_d[i] = timer[i] - 8'd1;
            end else begin
              timer_d[i]  = '0;
              active_d[i] = 1'b1;
`ifdef APPLE_LFSR_RESPAWN_EN
              x_d[i*APPLE_W +: APPLE_W]   = rnd_x;
              y_d[i*APPLE_YW +: APPLE_YW] = rnd_y;
`else
              x_d[i*APPLE_W +: APPLE_W]   = home_x(i);
              y_d[i*APPLE_YW +: APPLE_YW] = home_y(i);
`endif
            end
          end
        end
        if (idx == IDX_W'(NUM_APPLES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh hit on the servicing cycle survives the clear
    hit_latch_d = (hit_latch & ~clr) | hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      active    <= '1;
      hit_latch <= '0;
      score     <= '0;
      eat_pulse <= 1'b0;
      for (int i = 0; i < int'(NUM_APPLES); i++) begin
        timer[i]                        <= '0;
        apple_x[i*APPLE_W +: APPLE_W]   <= home_x(i);
        apple_y[i*APPLE_YW +: APPLE_YW] <= home_y(i);
      end
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      busy      <= busy_d;
      active    <= active_d;
      hit_latch <= hit_latch_d;
      score     <= score_d;
      eat_pulse <= eat_d;
      timer     <= timer_d;
      apple_x   <= x_d;
      apple_y   <= y_d;
    end
  end

endmodule

// File: tb/tb_apple_scheduler.sv
// Self-checking bench for apple_scheduler (5 slots, 3-frame respawn).
module tb_apple_scheduler;

  localparam int N = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          update = 1'b0;
  logic [N-1:0]  hit = '0;
  logic [N*10-1:0] apple_x;
  logic [N*9-1:0]  apple_y;
  logic [N-1:0]  active;
  logic [7:0]    score;
  logic          eat_pulse;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int eat_cnt = 0;
  int respawns = 0;
  bit mon_en = 1'b0;
  logic [N-1:0] prev_active = '1;

  int ref_x [N] = '{35, 135, 205, 440, 600};
  int ref_y [N] = '{80, 300, 400, 290, 50};

  typedef struct {
    logic [N-1:0] hit;
    logic [N-1:0] act;
    logic [7:0]   score;
  } vec_t;
  vec_t tbl [9];

  apple_scheduler #(
    .NUM_APPLES     (N),
    .RESPAWN_FRAMES (3),
    .X_MAX          (626),
    .Y_MAX          (466)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .update    (update),
    .hit       (hit),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .active    (active),
    .score     (score),
    .eat_pulse (eat_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_defaults(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s x[%0d]", tag, i), longint'(apple_x[i*10 +: 10]), longint'(ref_x[i]));
      chk($sformatf("%s y[%0d]", tag, i), longint'(apple_y[i*9 +: 9]), longint'(ref_y[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hit = '0; update = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse hit, then update, then wait for the scan to complete
  task automatic frame(input logic [N-1:0] h);
    int n;
    hit = h;
    @(negedge clk);
    hit = '0; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("scan timeout", 1, 0);
  endtask

  // Lowest active slot as a one-hot hit mask
  function automatic logic [N-1:0] pick(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return N'(1) << i;
    return '0;
  endfunction

  always @(negedge clk) if (eat_pulse) eat_cnt++;

  // Every rising active bit is a respawn: its position must be legal
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        if (active[i] && !prev_active[i]) begin
          respawns++;
`ifdef APPLE_LFSR_RESPAWN_EN
          chk("respawn x range", longint'(apple_x[i*10 +: 10] <= 10'd626), 1);
          chk("respawn y range", longint'(apple_y[i*9 +: 9] <= 9'd466), 1);
`else
          chk("respawn x home", longint'(apple_x[i*10 +: 10]), longint'(ref_x[i]));
          chk("respawn y home", longint'(apple_y[i*9 +: 9]), longint'(ref_y[i]));
`endif
        end
      end
    end
    prev_active = active;
  end

  initial begin
    int bcnt;
    int e0;
    int nf;

    tbl[0] = '{hit: 5'b00010, act: 5'b11101, score: 8'd1};
    tbl[1] = '{hit: 5'b00000, act: 5'b11101, score: 8'd1};
    tbl[2] = '{hit: 5'b00010, act: 5'b11101, score: 8'd1};
    tbl[3] = '{hit: 5'b00000, act: 5'b11111, score: 8'd1};
    tbl[4] = '{hit: 5'b10001, act: 5'b01110, score: 8'd3};
    tbl[5] = '{hit: 5'b00100, act: 5'b01010, score: 8'd4};
    tbl[6] = '{hit: 5'b00000, act: 5'b01010, score: 8'd4};
    tbl[7] = '{hit: 5'b00000, act: 5'b11011, score: 8'd4};
    tbl[8] = '{hit: 5'b01000, act: 5'b10111, score: 8'd5};

    // Reset state
    do_reset();
    chk("reset active", longint'(active), 5'b11111);
    chk("reset score", longint'(score), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset eat_pulse", longint'(eat_pulse), 0);
    chk_defaults("reset");

    // Cycle-accurate single eat of slot 1
    hit = 5'b00010;
    @(negedge clk);
    hit = '0; update = 1'b1;
    @(negedge clk);                       // after update edge (cycle 1)
    update = 1'b0;
    bcnt = busy ? 1 : 0;
    chk("c1 active", longint'(active), 5'b11111);
    @(negedge clk);                       // slot 0 serviced
    bcnt += busy ? 1 : 0;
    chk("c2 eat_pulse idle", longint'(eat_pulse), 0);
    @(negedge clk);                       // slot 1 serviced
    bcnt += busy ? 1 : 0;
    chk("c3 active", longint'(active), 5'b11101);
    chk("c3 score", longint'(score), 1);
    chk("c3 eat_pulse", longint'(eat_pulse), 1);
    @(negedge clk);
    bcnt += busy ? 1 : 0;
    chk("c4 eat_pulse drop", longint'(eat_pulse), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bcnt += busy ? 1 : 0;
    end
    chk("busy cycles", longint'(bcnt), 5);
    chk("eat pulses", longint'(eat_cnt), 1);

    // Table of frames from a fresh reset
    do_reset();
    for (int r = 0; r < 9; r++) begin
      frame(tbl[r].hit);
      chk($sformatf("row%0d active", r), longint'(active), longint'(tbl[r].act));
      chk($sformatf("row%0d score", r), longint'(score), longint'(tbl[r].score));
      chk($sformatf("row%0d busy", r), longint'(busy), 0);
`ifndef APPLE_LFSR_RESPAWN_EN
      if (r == 3) begin
        chk("respawn1 x", longint'(apple_x[19:10]), 135);
        chk("respawn1 y", longint'(apple_y[17:9]), 300);
      end
`endif
    end

    // Update during a scan is dropped; reset mid-scan restores everything
    do_reset();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    @(negedge clk);
    update = 1'b1;                        // sampled on the cycle-2 edge
    @(negedge clk);
    update = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                       // five service edges done
    chk("ignored update busy", longint'(busy), 0);
    @(negedge clk);
    chk("ignored update stays idle", longint'(busy), 0);

    hit = 5'b11111;
    @(negedge clk);
    hit = '0; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset score", longint'(score), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan active", longint'(active), 5'b11111);
    chk("midscan score", longint'(score), 0);
    chk("midscan busy", longint'(busy), 0);
    chk("midscan eat_pulse", longint'(eat_pulse), 0);
    chk_defaults("midscan");
    frame('0);
    chk("post-reset latch clear", longint'(score), 0);
    chk("post-reset active", longint'(active), 5'b11111);

    // Score saturation
    do_reset();
    nf = 0;
    while (score < 8'd254 && nf < 1000) begin
      frame(pick(active));
      nf++;
    end
    chk("score preload", longint'(score), 254);
    e0 = eat_cnt;
    for (int k = 0; k < 3; k++) frame(pick(active));
    chk("score saturate", longint'(score), 255);
    chk("saturated pulses", longint'(eat_cnt - e0), 3);

    // Long respawn run
    do_reset();
    @(negedge clk);
    mon_en = 1'b1;
    nf = 0;
    while (respawns < 1000 && nf < 1500) begin
      frame('1);
      nf++;
    end
    mon_en = 1'b0;
    chk("respawn count", longint'(respawns >= 1000), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
